// File: rtl/add_serial_pkg.sv
// Shared constants for the serial-adder scheduler.
// FSM encodings and default sizing.
package add_serial_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_ADD  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/add_serial_core.sv
// Bit-serial LSB-first adder datapath.
// Operand shifters, carry flop, result shifter, bit counter.
module add_serial_core
  import add_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_bit,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = cnt_w(WIDTH);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s;

  assign s        = a_q[0] ^ b_q[0] ^ c_q;
  assign carry    = (a_q[0] & b_q[0]) |
                    (a_q[0] & c_q) |
                    (b_q[0] & c_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  // Result as it will stand once the current bit lands.
  assign sum      = {s, res_q[WIDTH-1:1]};

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    res_d = res_q;
    c_d   = c_q;
    cnt_d = cnt_q;
    if (load) begin
      a_d   = a_i;
      b_d   = b_i;
      res_d = '0;
      c_d   = 1'b0;
      cnt_d = '0;
    end else if (step) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      res_d = sum;
      c_d   = carry;
      if (!last_bit) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
      c_q   <= c_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/add_serial_sched.sv
// Round-robin scheduler sharing one bit-serial adder.
// Holds FSM, round-robin pointer and result registers.
module add_serial_sched
  import add_serial_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      out,
  output logic                  cout,
  output logic                  valid,
  output logic [IDW-1:0]        valid_id
);

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   cur_q, cur_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic [IDW-1:0]   vid_q, vid_d;
  logic             valid_q, valid_d;

  logic [IDW-1:0]   pick;
  logic             found;
  logic             c_load, c_step;
  logic             c_last;
  logic [WIDTH-1:0] c_sum;
  logic             c_carry;
  logic [WIDTH-1:0] a_sel, b_sel;

  assign a_sel = a_in[int'(cur_q)*WIDTH +: WIDTH];
  assign b_sel = b_in[int'(cur_q)*WIDTH +: WIDTH];

  // Search starts just after the last winner and wraps.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(last_q) + k) % NREQ;
      if (!found && req[idx]) begin
        pick  = IDW'(idx);
        found = 1'b1;
      end
    end
  end

  assign c_load = (state_q == S_LOAD);
  assign c_step = (state_q == S_ADD);

  add_serial_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (c_load),
    .step    (c_step),
    .a_i     (a_sel),
    .b_i     (b_sel),
    .last_bit(c_last),
    .sum     (c_sum),
    .carry   (c_carry)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    out_d   = out_q;
    cout_d  = cout_q;
    vid_d   = vid_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          cur_d   = pick;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        last_d  = cur_q;
        state_d = S_ADD;
      end
      S_ADD: begin
        if (c_last) begin
          out_d   = c_sum;
          cout_d  = c_carry;
          vid_d   = cur_q;
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      last_q  <= IDW'(NREQ - 1);
      out_q   <= '0;
      cout_q  <= 1'b0;
      vid_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      vid_q   <= vid_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    gnt = '0;
    if (state_q == S_LOAD) gnt[cur_q] = 1'b1;
  end

  assign busy     = (state_q != S_IDLE);
  assign out      = out_q;
  assign cout     = cout_q;
  assign valid    = valid_q;
  assign valid_id = vid_q;

endmodule

// File: tb/tb_add_serial_sched.sv
// Bench for add_serial_sched: vector table plus
// arbitration, reset and fairness sequences.
module tb_add_serial_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in, b_in;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [WIDTH-1:0]      out;
  logic                  cout;
  logic                  valid;
  logic [IDW-1:0]        valid_id;

  logic [WIDTH-1:0] a_op [NREQ];
  logic [WIDTH-1:0] b_op [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign a_in[g*WIDTH +: WIDTH] = a_op[g];
    assign b_in[g*WIDTH +: WIDTH] = b_op[g];
  end

  add_serial_sched #(
    .NREQ (NREQ),
    .WIDTH(WIDTH),
    .IDW  (IDW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .a_in    (a_in),
    .b_in    (b_in),
    .gnt     (gnt),
    .busy    (busy),
    .out     (out),
    .cout    (cout),
    .valid   (valid),
    .valid_id(valid_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    int             id;
    logic [WIDTH:0] sum;
  } sb_t;

  int  exp_gnt [$];
  sb_t sb [$];
  int  gnt_cnt = 0;
  int  vcnt = 0;
  int  last_gnt_cyc = 0;
  int  last_valid_cyc = 0;
  int  gid;
  sb_t e;

  always @(negedge clk) begin
    if (gnt != '0) begin
      gid = 0;
      for (int i = 0; i < NREQ; i++) if (gnt[i]) gid = i;
      chk("gnt_onehot", $countones(gnt), 1);
      chk("gnt_busy", busy, 1);
      chk("gnt_valid_excl", valid, 0);
      if (exp_gnt.size() == 0) chk("gnt_unexpected", gid, 99);
      else chk("gnt_order", gid, exp_gnt.pop_front());
      sb.push_back('{gid, {1'b0, a_op[gid]} + {1'b0, b_op[gid]}});
      gnt_cnt++;
      last_gnt_cyc = cyc;
    end
    if (valid) begin
      if (sb.size() == 0) chk("valid_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        chk("sb_valid_id", valid_id, e.id);
        chk("sb_sum", {cout, out}, e.sum);
      end
      vcnt++;
      last_valid_cyc = cyc;
    end
  end

  task automatic wait_gnt(input int target, input int budget);
    int k = 0;
    while (gnt_cnt < target && k < budget) begin
      tick();
      k++;
    end
    chk("gnt_timeout", gnt_cnt >= target, 1);
  endtask

  task automatic wait_valid(input int target, input int budget);
    int k = 0;
    while (vcnt < target && k < budget) begin
      tick();
      k++;
    end
    chk("valid_timeout", vcnt >= target, 1);
  endtask

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] eo;
    logic       ec;
  } vec_t;

  vec_t vt [7];

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, g0, v0, prev;

    vt[0] = '{0, 8'h35, 8'h4A, 8'h7F, 1'b0};
    vt[1] = '{2, 8'hFF, 8'h01, 8'h00, 1'b1};
    vt[2] = '{2, 8'h80, 8'h80, 8'h00, 1'b1};
    vt[3] = '{1, 8'h00, 8'h00, 8'h00, 1'b0};
    vt[4] = '{3, 8'hAA, 8'h55, 8'hFF, 1'b0};
    vt[5] = '{1, 8'hC3, 8'h7E, 8'h41, 1'b1};
    vt[6] = '{0, 8'hFF, 8'hFF, 8'hFE, 1'b1};

    rst = 1'b0;
    req = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
    end
    repeat (3) tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_out", out, 0);
    chk("rst_cout", cout, 0);
    chk("rst_vid", valid_id, 0);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      a_op[vt[i].id] = vt[i].a;
      b_op[vt[i].id] = vt[i].b;
      exp_gnt.push_back(vt[i].id);
      c0  = cyc;
      g0  = gnt_cnt;
      v0  = vcnt;
      req = NREQ'(1 << vt[i].id);
      wait_gnt(g0 + 1, 5);
      req = '0;
      chk("tbl_gnt_lat", last_gnt_cyc - c0, 1);
      wait_valid(v0 + 1, 20);
      chk("tbl_valid_lat", last_valid_cyc - c0, WIDTH + 2);
      chk("tbl_out", out, vt[i].eo);
      chk("tbl_cout", cout, vt[i].ec);
      chk("tbl_vid", valid_id, vt[i].id);
      tick();
      chk("tbl_idle", busy, 0);
    end

    // all requesters held high from reset
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      a_op[i] = 8'(8'h31 * (i + 1));
      b_op[i] = 8'(8'h57 + 8'h22 * i);
    end
    req = '1;
    repeat (2) tick();
    exp_gnt = '{0, 1, 2, 3, 0};
    g0  = gnt_cnt;
    v0  = vcnt;
    c0  = cyc;
    rst = 1'b1;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(g0 + k + 1, 15);
      if (k == 0) chk("rr_first_lat", last_gnt_cyc - c0, 1);
      else chk("rr_spacing", last_gnt_cyc - prev, WIDTH + 3);
      prev = last_gnt_cyc;
    end
    req = '0;
    wait_valid(v0 + 5, 30);
    tick();
    chk("rr_expq", exp_gnt.size(), 0);
    chk("rr_sbq", sb.size(), 0);

    // fairness: req0 held, req2 raised mid-op
    a_op[0] = 8'h12; b_op[0] = 8'hF0;
    a_op[2] = 8'h9C; b_op[2] = 8'h7D;
    exp_gnt = '{0, 2, 0, 2};
    g0  = gnt_cnt;
    v0  = vcnt;
    req = 4'b0001;
    repeat (5) tick();
    req = 4'b0101;
    wait_gnt(g0 + 4, 60);
    req = '0;
    wait_valid(v0 + 4, 20);
    tick();
    chk("fair_expq", exp_gnt.size(), 0);

    // reset during ADD discards the op
    a_op[0] = 8'h66; b_op[0] = 8'hA7;
    exp_gnt.push_back(0);
    g0  = gnt_cnt;
    v0  = vcnt;
    req = 4'b0001;
    wait_gnt(g0 + 1, 5);
    req = '0;
    repeat (5) tick();
    chk("mid_busy_pre", busy, 1);
    rst = 1'b0;
    tick();
    chk("mid_busy", busy, 0);
    chk("mid_gnt", gnt, 0);
    chk("mid_valid", valid, 0);
    chk("mid_out", out, 0);
    chk("mid_cout", cout, 0);
    chk("mid_vid", valid_id, 0);
    sb.delete();
    rst = 1'b1;
    repeat (12) tick();
    chk("mid_no_valid", vcnt, v0);
    a_op[1] = 8'h0F; b_op[1] = 8'hF1;
    exp_gnt = '{0, 1};
    g0  = gnt_cnt;
    v0  = vcnt;
    req = 4'b0011;
    wait_gnt(g0 + 2, 30);
    req = '0;
    wait_valid(v0 + 2, 20);
    tick();

    // req1 pulse while busy is never seen
    a_op[3] = 8'h44; b_op[3] = 8'h3B;
    exp_gnt.push_back(3);
    g0  = gnt_cnt;
    v0  = vcnt;
    req = 4'b1000;
    wait_gnt(g0 + 1, 5);
    req = '0;
    repeat (3) tick();
    req = 4'b0010;
    tick();
    req = '0;
    repeat (20) tick();
    chk("drop_gnts", gnt_cnt, g0 + 1);
    chk("drop_valids", vcnt, v0 + 1);
    chk("drop_expq", exp_gnt.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_serial_sched.md
# add_serial_sched

Round-robin scheduler that shares one bit-serial adder among `NREQ` requesters. It arbitrates pending requests, captures the winner's operands, and sequences the LSB-first serial add over `WIDTH` cycles. It then returns the sum, carry-out and requester ID with a one-cycle valid pulse. It sits between client blocks and the serial adder datapath, which it instantiates internally.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `WIDTH`, default 8: operand/result width in bits.
- `IDW`, default `$clog2(NREQ)`: requester-ID width.
- `clk`  input  1  single clock, all state updates on rising edge.
- `rst`  input  1  reset; synchronous, active-low (asserted when 0, sampled on `clk` rising edge).
- `req`  input  NREQ  per-requester request, level.
- `a_in`  input  NREQ*WIDTH  operand A of requester i at bits [i*WIDTH +: WIDTH].
- `b_in`  input  NREQ*WIDTH  operand B, same packing.
- `gnt`  output  NREQ  one-hot grant pulse; operands of that requester are captured this cycle.
- `busy`  output  1  high in every state except IDLE.
- `out`  output  WIDTH  sum modulo 2^WIDTH, registered and held until the next DONE.
- `cout`  output  1  final carry of the add, held with `out`.
- `valid`  output  1  one-cycle pulse when `out`/`cout`/`valid_id` update.
- `valid_id`  output  IDW  index of the requester owning the result.

## Operation
- States: IDLE, LOAD, ADD, DONE.
- **IDLE**
  - If any `req` bit is high, pick a winner round-robin: search starts at `last+1` and wraps at NREQ.
  - Register the winner as `cur_id` and go to LOAD. Otherwise stay in IDLE.
- **LOAD**
  - Assert `gnt[cur_id]`.
  - Capture `a_in`/`b_in` slices of `cur_id` into shift registers.
  - Clear the carry and the bit counter, set `last <= cur_id`, go to ADD.
- **ADD**
  - Each cycle: sum bit = a0^b0^carry; carry <= majority(a0,b0,carry).
  - Shift the sum bit into the result register MSB-first, so after WIDTH cycles bit 0 ends at LSB.
  - Shift both operand registers right by 1.
  - Counter increments. When the counter equals WIDTH-1, go to DONE.
- **DONE**
  - Assert `valid`. Load `out`, `cout` and `valid_id = cur_id`.
  - Always go to IDLE next; there is no direct DONE→LOAD path.
- Arbitration rules:
  - Only `req` values in the IDLE cycle count.
  - `req` changes during LOAD/ADD/DONE are ignored.
  - A requester may deassert `req` after its `gnt`. If it keeps `req` high, it is re-served only after the other pending requesters, per round-robin.
- Arithmetic: unsigned. `{cout,out} = a + b` exactly, with the full WIDTH+1 bits.
- Counter width is `$clog2(WIDTH)`. It never wraps during a valid op.

## Timing
- Request seen in IDLE at cycle t, then:
  - `gnt` at t+1.
  - ADD during t+2 … t+1+WIDTH.
  - `valid` at t+2+WIDTH (t+10 for WIDTH=8).
- Next arbitration is at t+3+WIDTH, so throughput is one op per WIDTH+3 cycles when requests are continuous.
- Reset values (`rst`=0 at an edge):
  - `state`=IDLE; `gnt`=0, `busy`=0, `valid`=0.
  - `out`=0, `cout`=0, `valid_id`=0.
  - carry and counter = 0.
  - `last`=NREQ-1, so requester 0 has first priority.
- Reset mid-operation, in any state: the next cycle is IDLE with the reset values above. The in-flight result is discarded and no `valid` is produced.
- Simultaneous requests: exactly one `gnt` bit per op; `gnt` is never high outside LOAD.
- `valid` and `gnt` are never high in the same cycle.

## Structure
- Shared package `add_serial_pkg`:
  - state enum {IDLE, LOAD, ADD, DONE} as 2-bit localparams.
  - default WIDTH/NREQ constants.
- Sub-module `add_serial_core` holds the datapath:
  - operand shift registers, carry flop, result shift register, bit counter.
  - control inputs `load`/`step`; outputs `last_bit` and `sum`/`carry`.
- The top holds the FSM, round-robin pointer and output registers.

## Test plan
1. Single request: `req`=0001, a=0x35, b=0x4A at cycle 0 → `gnt`=0001 at cycle 1; `valid` at cycle 10 with `out`=0x7F, `cout`=0, `valid_id`=0.
2. Overflow: a=0xFF, b=0x01 on requester 2 → `out`=0x00, `cout`=1, `valid_id`=2. Also a=0x80, b=0x80 → `out`=0x00, `cout`=1.
3. All four `req` held high from reset → grants in order 0,1,2,3,0, spaced 11 cycles apart; each `valid_id` matches its operands' sums.
4. Fairness: `req[0]` held high continuously, `req[2]` raised at cycle 5 → grant order 0,2,0,2.
5. Reset mid-ADD: assert `rst`=0 at cycle 5 of an add → next cycle IDLE, all outputs 0, no `valid`. A following request to requester 0 is granted first.
6. Request dropped before arbitration: `req[1]` pulses high in a cycle where `busy`=1 and falls before IDLE → no `gnt[1]`, no `valid`.
